decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 63 ++++++
 rtl/decode_stage_imm_gen.sv | 26 ++
 rtl/decode_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32 opcodes, ALU class codes and ctrl bit positions.
// Also used by the ALU control unit; HAZARD_DETECT_EN consumers rely on uses_rs2().
package decode_stage_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_FUNCT  = 2'b10
    } alu_op_e;

    // ctrl = {RegWrite, MemRead, MemWrite, Branch, ALUSrc, MemtoReg}
    localparam int CTRL_REG_WRITE  = 5;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_ALU_SRC    = 1;
    localparam int CTRL_MEM_TO_REG = 0;

    typedef struct packed {
        alu_op_e    alu_op;
        logic [5:0] ctrl;
        logic       illegal;
    } dec_t;

    function automatic dec_t decode_opcode(input logic [6:0] opc);
        dec_t d;
        d.alu_op  = ALU_OP_ADD;
        d.ctrl    = '0;
        d.illegal = 1'b0;
        case (opc)
            OPC_RTYPE: begin
                d.alu_op                 = ALU_OP_FUNCT;
                d.ctrl[CTRL_REG_WRITE]   = 1'b1;
            end
            OPC_LOAD: begin
                d.ctrl[CTRL_REG_WRITE]   = 1'b1;
                d.ctrl[CTRL_MEM_READ]    = 1'b1;
                d.ctrl[CTRL_ALU_SRC]     = 1'b1;
                d.ctrl[CTRL_MEM_TO_REG]  = 1'b1;
            end
            OPC_STORE: begin
                d.ctrl[CTRL_MEM_WRITE]   = 1'b1;
                d.ctrl[CTRL_ALU_SRC]     = 1'b1;
            end
            OPC_BRANCH: begin
                d.alu_op                 = ALU_OP_BRANCH;
                d.ctrl[CTRL_BRANCH]      = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational sign-extended immediate extraction for LW, SW and BEQ.
// Every other opcode (including R-type and illegal ones) yields zero.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    logic unused_bits;
    assign unused_bits = ^instr[19:12];

    always_comb begin
        imm = '0;
        case (instr[6:0])
            OPC_LOAD:   imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OPC_STORE:  imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            default:    imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-cycle valid/ready decode register for a subset of RV32I.
// Optional load-use stall when HAZARD_DETECT_EN is defined.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [1:0]      ALU_Op,
    output logic [6:0]      fun7,
    output logic [2:0]      fun3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [5:0]      ctrl,
    output logic            illegal
);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, imm_q;
    alu_op_e         alu_op_q;
    logic [6:0]      fun7_q;
    logic [2:0]      fun3_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [5:0]      ctrl_q;
    logic            illegal_q;

    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] imm_w;
    dec_t            dec_w;

    assign dec_w = decode_opcode(instr[6:0]);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr),
        .imm   (imm_w)
    );

`ifdef HAZARD_DETECT_EN
    // Load-use: the held load's result is not yet available to a dependent instruction.
    assign hazard = out_valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != '0) &&
                    ((instr[19:15] == rd_q) ||
                     (uses_rs2(instr[6:0]) && (instr[24:20] == rd_q)));
`else
    assign hazard = 1'b0;
`endif

    assign in_ready = (!out_valid_q || out_ready) && !flush && !hazard;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)          out_valid_d = 1'b0;
        else if (accept)    out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            imm_q       <= '0;
            alu_op_q    <= ALU_OP_ADD;
            fun7_q      <= '0;
            fun3_q      <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_pc_q  <= pc;
                imm_q     <= imm_w;
                alu_op_q  <= dec_w.alu_op;
                fun7_q    <= instr[31:25];
                fun3_q    <= instr[14:12];
                rs1_q     <= instr[19:15];
                rs2_q     <= instr[24:20];
                rd_q      <= instr[11:7];
                ctrl_q    <= dec_w.ctrl;
                illegal_q <= dec_w.illegal;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign imm       = imm_q;
    assign ALU_Op    = alu_op_q;
    assign fun7      = fun7_q;
    assign fun3      = fun3_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign ctrl      = ctrl_q;
    assign illegal   = illegal_q;

endmodule
